// File: rtl/load_store_unit.sv
// load_store_unit: CPU-side initiator for the unified memory's word-wide data port.
// It accepts byte, half and word loads and stores over a valid/ready handshake. The memory is
// little-endian with a combinational read, so sub-word stores are done as read-modify-write.
//
// Optional feature macro: LSU_STATS_EN adds saturating per-kind completion counters.
//
// Ports:
//   clk, rst_n                  clock (rising edge), asynchronous active-low reset
//   req_valid / req_ready       request handshake; ready only while idle
//   req_write, req_size,        store flag, size (00 byte, 01 half, 10 word, 11 illegal),
//   req_signed, req_addr,       sign-extend flag for loads, byte address,
//   req_wdata                   store data (low bytes used for sub-word stores)
//   resp_valid, resp_rdata,     one-cycle completion pulse, extended load data,
//   resp_error                  misaligned / out-of-range / illegal-size flag
//   mem_addr, mem_wdata,        word-aligned address and write word to memory
//   mem_read, mem_write         memory enables (never both high)
//   mem_rdata                   combinational read data from memory
//   stat_loads/stores/errors    (LSU_STATS_EN only) 16-bit saturating counters
module load_store_unit #(
    parameter int unsigned WRITE_HOLD = 2,
    parameter logic [31:0] DATA_LIMIT = 32'h0000_3000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_error,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        mem_read,
    output logic        mem_write,
    input  logic [31:0] mem_rdata
`ifdef LSU_STATS_EN
    ,
    output logic [15:0] stat_loads,
    output logic [15:0] stat_stores,
    output logic [15:0] stat_errors
`endif
);

    typedef enum logic [1:0] {StIdle, StRead, StWrite, StResp} state_e;

    localparam int unsigned CntW = (WRITE_HOLD > 1) ? $clog2(WRITE_HOLD) : 1;
    localparam logic [CntW-1:0] HoldLoad = CntW'(WRITE_HOLD - 1);

    state_e          state_q, state_d;
    logic            req_ready_q, req_ready_d;
    logic            resp_valid_q, resp_valid_d;
    logic            resp_error_q, resp_error_d;
    logic [31:0]     resp_rdata_q, resp_rdata_d;
    logic [31:0]     mem_addr_q, mem_addr_d;
    logic [31:0]     mem_wdata_q, mem_wdata_d;
    logic            mem_read_q, mem_read_d;
    logic            mem_write_q, mem_write_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            wr_q, wr_d;
    logic [1:0]      size_q, size_d;
    logic            signed_q, signed_d;
    logic [1:0]      lane_q, lane_d;
    logic [31:0]     wdata_q, wdata_d;

    // Acceptance-time legality check
    logic        acc_error;
    logic [32:0] last_byte;

    always_comb begin
        acc_error = 1'b0;
        last_byte = {1'b0, req_addr};
        case (req_size)
            2'b00: last_byte = {1'b0, req_addr};
            2'b01: begin
                last_byte = {1'b0, req_addr} + 33'd1;
                if (req_addr[0]) acc_error = 1'b1;
            end
            2'b10: begin
                last_byte = {1'b0, req_addr} + 33'd3;
                if (req_addr[1:0] != 2'b00) acc_error = 1'b1;
            end
            default: acc_error = 1'b1;
        endcase
        // 33-bit compare so an access wrapping past 0xFFFF_FFFF is still caught
        if (last_byte >= {1'b0, DATA_LIMIT}) acc_error = 1'b1;
    end

    // Lane handling: a half is always at lane 0 or 2, so the byte offset works for both sizes
    logic [4:0]  lane_shift;
    logic [31:0] rd_shifted;
    logic [31:0] load_data;
    logic [31:0] lane_mask;
    logic [31:0] merged;

    always_comb begin
        lane_shift = {lane_q, 3'b000};
        rd_shifted = mem_rdata >> lane_shift;
        case (size_q)
            2'b00: begin
                load_data = signed_q ? {{24{rd_shifted[7]}}, rd_shifted[7:0]}
                                     : {24'h0, rd_shifted[7:0]};
                lane_mask = 32'h0000_00FF << lane_shift;
            end
            2'b01: begin
                load_data = signed_q ? {{16{rd_shifted[15]}}, rd_shifted[15:0]}
                                     : {16'h0, rd_shifted[15:0]};
                lane_mask = 32'h0000_FFFF << lane_shift;
            end
            default: begin
                load_data = rd_shifted;
                lane_mask = 32'hFFFF_FFFF;
            end
        endcase
        merged = (mem_rdata & ~lane_mask) | ((wdata_q << lane_shift) & lane_mask);
    end

    always_comb begin
        state_d      = state_q;
        req_ready_d  = req_ready_q;
        resp_valid_d = 1'b0;
        resp_error_d = 1'b0;
        resp_rdata_d = 32'h0;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        mem_read_d   = 1'b0;
        mem_write_d  = 1'b0;
        cnt_d        = cnt_q;
        wr_d         = wr_q;
        size_d       = size_q;
        signed_d     = signed_q;
        lane_d       = lane_q;
        wdata_d      = wdata_q;

        case (state_q)
            StIdle: begin
                if (req_valid && req_ready_q) begin
                    req_ready_d = 1'b0;
                    wr_d        = req_write;
                    size_d      = req_size;
                    signed_d    = req_signed;
                    lane_d      = req_addr[1:0];
                    wdata_d     = req_wdata;
                    mem_addr_d  = {req_addr[31:2], 2'b00};
                    if (acc_error) begin
                        state_d      = StResp;
                        resp_valid_d = 1'b1;
                        resp_error_d = 1'b1;
                    end else if (!req_write || req_size != 2'b10) begin
                        state_d    = StRead;
                        mem_read_d = 1'b1;
                    end else begin
                        state_d     = StWrite;
                        mem_write_d = 1'b1;
                        mem_wdata_d = req_wdata;
                        cnt_d       = HoldLoad;
                    end
                end
            end
            StRead: begin
                if (wr_q) begin
                    state_d     = StWrite;
                    mem_write_d = 1'b1;
                    mem_wdata_d = merged;
                    cnt_d       = HoldLoad;
                end else begin
                    state_d      = StResp;
                    resp_valid_d = 1'b1;
                    resp_rdata_d = load_data;
                end
            end
            StWrite: begin
                if (cnt_q == '0) begin
                    state_d      = StResp;
                    resp_valid_d = 1'b1;
                end else begin
                    cnt_d       = cnt_q - CntW'(1);
                    mem_write_d = 1'b1;
                end
            end
            StResp: begin
                state_d     = StIdle;
                req_ready_d = 1'b1;
            end
            default: begin
                state_d     = StIdle;
                req_ready_d = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            req_ready_q  <= 1'b1;
            resp_valid_q <= 1'b0;
            resp_error_q <= 1'b0;
            resp_rdata_q <= 32'h0;
            mem_addr_q   <= 32'h0;
            mem_wdata_q  <= 32'h0;
            mem_read_q   <= 1'b0;
            mem_write_q  <= 1'b0;
            cnt_q        <= '0;
            wr_q         <= 1'b0;
            size_q       <= 2'b00;
            signed_q     <= 1'b0;
            lane_q       <= 2'b00;
            wdata_q      <= 32'h0;
        end else begin
            state_q      <= state_d;
            req_ready_q  <= req_ready_d;
            resp_valid_q <= resp_valid_d;
            resp_error_q <= resp_error_d;
            resp_rdata_q <= resp_rdata_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            mem_read_q   <= mem_read_d;
            mem_write_q  <= mem_write_d;
            cnt_q        <= cnt_d;
            wr_q         <= wr_d;
            size_q       <= size_d;
            signed_q     <= signed_d;
            lane_q       <= lane_d;
            wdata_q      <= wdata_d;
        end
    end

    assign req_ready  = req_ready_q;
    assign resp_valid = resp_valid_q;
    assign resp_error = resp_error_q;
    assign resp_rdata = resp_rdata_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;
    assign mem_read   = mem_read_q;
    assign mem_write  = mem_write_q;

`ifdef LSU_STATS_EN
    logic [15:0] stat_loads_q, stat_stores_q, stat_errors_q;

    // resp_valid_q is high exactly for the RESP cycle, so each response counts once
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_loads_q  <= 16'h0;
            stat_stores_q <= 16'h0;
            stat_errors_q <= 16'h0;
        end else if (resp_valid_q) begin
            if (resp_error_q) begin
                if (stat_errors_q != 16'hFFFF) stat_errors_q <= stat_errors_q + 16'd1;
            end else if (wr_q) begin
                if (stat_stores_q != 16'hFFFF) stat_stores_q <= stat_stores_q + 16'd1;
            end else begin
                if (stat_loads_q != 16'hFFFF) stat_loads_q <= stat_loads_q + 16'd1;
            end
        end
    end

    assign stat_loads  = stat_loads_q;
    assign stat_stores = stat_stores_q;
    assign stat_errors = stat_errors_q;
`endif

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed scenarios plus randomized traffic against a
// byte-addressed reference memory. Build with LSU_STATS_EN to also cover the counters.
module tb_load_store_unit;

    localparam int unsigned HOLD  = 2;
    localparam longint      LIMIT = 'h3000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid, req_ready, req_write, req_signed;
    logic [1:0]  req_size;
    logic [31:0] req_addr, req_wdata;
    logic        resp_valid, resp_error;
    logic [31:0] resp_rdata;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_read, mem_write;
`ifdef LSU_STATS_EN
    logic [15:0] stat_loads, stat_stores, stat_errors;
`endif

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    load_store_unit #(
        .WRITE_HOLD(HOLD),
        .DATA_LIMIT(32'h0000_3000)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_write  (req_write),
        .req_size   (req_size),
        .req_signed (req_signed),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_error (resp_error),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .mem_rdata  (mem_rdata)
`ifdef LSU_STATS_EN
        ,
        .stat_loads (stat_loads),
        .stat_stores(stat_stores),
        .stat_errors(stat_errors)
`endif
    );

    // Memory attached to the DUT; preload port used only while the DUT is idle
    logic [31:0] mem [0:4095];
    logic        pl_en = 1'b0;
    logic [31:0] pl_addr = 32'h0;
    logic [31:0] pl_data = 32'h0;

    assign mem_rdata = mem_read ? mem[mem_addr[13:2]] : 32'h0;

    always @(posedge clk) begin
        if (pl_en) mem[pl_addr[13:2]] <= pl_data;
        else if (mem_write) mem[mem_addr[13:2]] <= mem_wdata;
    end

    // Reference model: plain byte array
    logic [7:0] ref_mem [0:16383];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ref_word(input logic [31:0] a);
        return {ref_mem[a+3], ref_mem[a+2], ref_mem[a+1], ref_mem[a]};
    endfunction

    function automatic logic [31:0] ref_load(input logic [1:0] sz, input logic sg,
                                             input logic [31:0] a);
        longint v;
        int     nb;
        nb = 1 << sz;
        v  = 0;
        for (int i = 0; i < nb; i++) v += longint'(ref_mem[a+i]) << (8 * i);
        if (sg && nb < 4 && v >= (longint'(1) << (8 * nb - 1))) v -= longint'(1) << (8 * nb);
        return v[31:0];
    endfunction

    task automatic preload(input logic [31:0] a, input logic [31:0] w);
        pl_en   = 1'b1;
        pl_addr = a;
        pl_data = w;
        for (int i = 0; i < 4; i++) ref_mem[a+i] = w[8*i +: 8];
        @(posedge clk);
        #1;
        pl_en = 1'b0;
    endtask

    // One complete transaction with protocol checks; returns observed data, error, write word
    task automatic do_req(input logic wr, input logic [1:0] sz, input logic sg,
                          input logic [31:0] addr, input logic [31:0] wd,
                          output logic [31:0] o_rdata, output logic o_err,
                          output logic [31:0] o_wword);
        logic        exp_err, got;
        logic [31:0] exp_rdata, exp_word;
        int          nb, exp_lat, exp_reads, exp_writes, lat, reads, writes, guard;
        longint      a;
        a = addr;
        nb = 0;
        if (sz == 2'd3) exp_err = 1'b1;
        else begin
            nb = 1 << sz;
            exp_err = ((a % nb) != 0) || (a + nb - 1 >= LIMIT);
        end
        exp_rdata = 32'h0;
        exp_word  = 32'h0;
        if (exp_err) begin
            exp_lat = 1; exp_reads = 0; exp_writes = 0;
        end else if (!wr) begin
            exp_rdata = ref_load(sz, sg, addr);
            exp_lat = 2; exp_reads = 1; exp_writes = 0;
        end else begin
            for (int i = 0; i < nb; i++) ref_mem[addr+i] = wd[8*i +: 8];
            exp_word = ref_word(addr & ~32'h3);
            exp_lat    = (sz == 2'd2) ? HOLD + 1 : HOLD + 2;
            exp_reads  = (sz == 2'd2) ? 0 : 1;
            exp_writes = HOLD;
        end

        req_valid = 1'b1; req_write = wr; req_size = sz; req_signed = sg;
        req_addr = addr; req_wdata = wd;
        guard = 0;
        while (!req_ready && guard < 50) begin
            @(posedge clk); #1; guard++;
        end
        check("ready_wait", {31'h0, req_ready}, 32'h1);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        check("ready_drop", {31'h0, req_ready}, 32'h0);

        o_wword = 32'h0;
        lat = 1; reads = 0; writes = 0; got = 1'b0;
        for (int c = 0; c < 20; c++) begin
            check("rw_excl", {31'h0, mem_read & mem_write}, 32'h0);
            if (mem_read) reads++;
            if (mem_write) begin
                writes++;
                o_wword = mem_wdata;
                check("wr_data", mem_wdata, exp_word);
            end
            if (mem_read || mem_write) check("mem_addr", mem_addr, addr & ~32'h3);
            if (resp_valid) begin
                got = 1'b1;
                break;
            end
            @(posedge clk);
            #1;
            lat++;
        end
        check("resp_seen", {31'h0, got}, 32'h1);
        check("latency", lat, exp_lat);
        check("reads", reads, exp_reads);
        check("writes", writes, exp_writes);
        check("resp_error", {31'h0, resp_error}, {31'h0, exp_err});
        check("resp_rdata", resp_rdata, exp_rdata);
        o_rdata = resp_rdata;
        o_err   = resp_error;
        @(posedge clk);
        #1;
        check("resp_pulse", {31'h0, resp_valid}, 32'h0);
        check("ready_back", {31'h0, req_ready}, 32'h1);
    endtask

    logic [31:0] r_data, r_word, exp_b2b;
    logic        r_err;
    int          acc, rsp, pulses;

    initial begin
        rst_n = 1'b0;
        req_valid = 1'b0; req_write = 1'b0; req_size = 2'b00; req_signed = 1'b0;
        req_addr = 32'h0; req_wdata = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_ready", {31'h0, req_ready}, 32'h1);
        check("rst_resp_valid", {31'h0, resp_valid}, 32'h0);
        check("rst_resp_error", {31'h0, resp_error}, 32'h0);
        check("rst_resp_rdata", resp_rdata, 32'h0);
        check("rst_mem_addr", mem_addr, 32'h0);
        check("rst_mem_wdata", mem_wdata, 32'h0);
        check("rst_mem_read", {31'h0, mem_read}, 32'h0);
        check("rst_mem_write", {31'h0, mem_write}, 32'h0);
        rst_n = 1'b1;

        for (int w = 0; w < 64; w++) preload(32'(w * 4), $urandom);
        for (int w = 0; w < 4; w++) preload(32'h2FF0 + 32'(w * 4), $urandom);

        // Word store then word load
        do_req(1'b1, 2'd2, 1'b0, 32'h10, 32'hDEAD_BEEF, r_data, r_err, r_word);
        check("t1_wword", r_word, 32'hDEAD_BEEF);
        do_req(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, r_data, r_err, r_word);
        check("t1_load", r_data, 32'hDEAD_BEEF);

        // Byte read-modify-write
        preload(32'h20, 32'h1122_3344);
        do_req(1'b1, 2'd0, 1'b0, 32'h22, 32'h0000_00AA, r_data, r_err, r_word);
        check("t2_merge", r_word, 32'h11AA_3344);
        do_req(1'b0, 2'd2, 1'b0, 32'h20, 32'h0, r_data, r_err, r_word);
        check("t2_load", r_data, 32'h11AA_3344);

        // Sub-word load extension
        preload(32'h30, 32'h80FF_7F01);
        do_req(1'b0, 2'd0, 1'b1, 32'h31, 32'h0, r_data, r_err, r_word);
        check("t3_lb_31", r_data, 32'h0000_007F);
        do_req(1'b0, 2'd0, 1'b1, 32'h32, 32'h0, r_data, r_err, r_word);
        check("t3_lb_32", r_data, 32'hFFFF_FFFF);
        do_req(1'b0, 2'd1, 1'b0, 32'h32, 32'h0, r_data, r_err, r_word);
        check("t3_lhu_32", r_data, 32'h0000_80FF);

        // Errors
        do_req(1'b0, 2'd2, 1'b0, 32'h6, 32'h0, r_data, r_err, r_word);
        check("t4_misalign_w", {31'h0, r_err}, 32'h1);
        do_req(1'b1, 2'd1, 1'b0, 32'h3, 32'h1234, r_data, r_err, r_word);
        check("t4_misalign_h", {31'h0, r_err}, 32'h1);
        do_req(1'b0, 2'd2, 1'b0, 32'h3000, 32'h0, r_data, r_err, r_word);
        check("t4_range", {31'h0, r_err}, 32'h1);
        do_req(1'b0, 2'd2, 1'b0, 32'h2FFC, 32'h0, r_data, r_err, r_word);
        check("t4_last_word", {31'h0, r_err}, 32'h0);

        // Reset during the first write cycle
        req_valid = 1'b1; req_write = 1'b1; req_size = 2'd2; req_signed = 1'b0;
        req_addr = 32'h40; req_wdata = 32'h1234_5678;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        check("t5_writing", {31'h0, mem_write}, 32'h1);
        rst_n = 1'b0;
        #1;
        check("t5_wr_drop", {31'h0, mem_write}, 32'h0);
        check("t5_rd_low", {31'h0, mem_read}, 32'h0);
        check("t5_no_resp", {31'h0, resp_valid}, 32'h0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        pulses = 0;
        for (int c = 0; c < 6; c++) begin
            if (resp_valid) pulses++;
            @(posedge clk);
            #1;
        end
        check("t5_pulses", pulses, 0);
        check("t5_ready", {31'h0, req_ready}, 32'h1);
        preload(32'h40, 32'hCAFE_F00D);

        // Counter mix directly after reset: 3 loads, 2 stores, 1 error
        do_req(1'b0, 2'd2, 1'b0, 32'h40, 32'h0, r_data, r_err, r_word);
        do_req(1'b0, 2'd0, 1'b1, 32'h41, 32'h0, r_data, r_err, r_word);
        do_req(1'b1, 2'd1, 1'b0, 32'h44, 32'h0000_BEEF, r_data, r_err, r_word);
        do_req(1'b0, 2'd1, 1'b0, 32'h44, 32'h0, r_data, r_err, r_word);
        do_req(1'b1, 2'd2, 1'b0, 32'h48, 32'h5555_AAAA, r_data, r_err, r_word);
        do_req(1'b0, 2'd3, 1'b0, 32'h48, 32'h0, r_data, r_err, r_word);
`ifdef LSU_STATS_EN
        check("stat_loads", {16'h0, stat_loads}, 32'd3);
        check("stat_stores", {16'h0, stat_stores}, 32'd2);
        check("stat_errors", {16'h0, stat_errors}, 32'd1);
`endif

        // req_valid held high: one accept per three cycles, one response per accept
        exp_b2b = ref_load(2'd2, 1'b0, 32'h10);
        req_valid = 1'b1; req_write = 1'b0; req_size = 2'd2; req_signed = 1'b0;
        req_addr = 32'h10; req_wdata = 32'h0;
        acc = 0; rsp = 0;
        for (int k = 0; k < 30; k++) begin
            if (req_ready) acc++;
            if (resp_valid) begin
                rsp++;
                check("b2b_rdata", resp_rdata, exp_b2b);
            end
            @(posedge clk);
            #1;
        end
        req_valid = 1'b0;
        for (int k = 0; k < 5; k++) begin
            if (resp_valid) rsp++;
            @(posedge clk);
            #1;
        end
        check("b2b_accepts", acc, 10);
        check("b2b_resps", rsp, 10);
`ifdef LSU_STATS_EN
        check("b2b_stat_loads", {16'h0, stat_loads}, 32'd13);
`endif

        // Randomized traffic
        for (int n = 0; n < 200; n++) begin
            logic [1:0]  sz;
            logic [31:0] ad;
            sz = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            ad = ($urandom_range(0, 99) < 85) ? 32'($urandom_range(0, 255))
                                              : 32'($urandom_range(32'h2FF0, 32'h3007));
            do_req(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), ad, $urandom,
                   r_data, r_err, r_word);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
